fetch_pc_generator: RTL and testbench
=====================================

# fetch_pc_generator

Program-counter generator for the IF stage of the MIPS pipeline. It is the registered, parametrised successor to the combinational fetch address mux. It holds the PC, advances it on I-cache hits, and freezes it on hazard stalls and cache misses. It applies taken-branch redirects from EX, queueing a redirect that arrives during a committed miss refill until that refill completes. It also exports the sequential next address to the IF/ID register and a saturating miss-cycle counter.

## Interface
Parameters:
- ADDR_W, 32, PC / address width in bits
- RESET_PC, 0, PC value loaded on reset
- INSTR_BYTES, 4, PC increment; must be a power of two
- CNT_W, 16, width of the miss-cycle counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- hit  input  1  I-cache hit for the current instruction_address
- stall  input  1  hazard-unit freeze of IF/ID
- PCSrc  input  1  taken branch/jump resolved in EX, one-cycle pulse
- address_branch  input  ADDR_W  redirect target, valid when PCSrc=1
- instruction_address  output  ADDR_W  current fetch PC, to the I-cache
- address_out  output  ADDR_W  instruction_address + INSTR_BYTES, to IF/ID
- fetch_valid  output  1  the instruction at instruction_address is accepted into IF/ID this cycle
- redirect_pending  output  1  a redirect is queued behind a miss
- miss_cycles  output  CNT_W  count of cycles spent in MISS, saturating

## Operation
- State machine: RUN, MISS. Held registers: pc, pend_target, pend_valid, state, miss_cycles.
- instruction_address = pc. address_out = pc + INSTR_BYTES, truncated to ADDR_W, so it wraps modulo 2^ADDR_W.
- Redirect targets have their low log2(INSTR_BYTES) bits forced to 0 before use.
- RUN, evaluated in priority order:
  - PCSrc=1: pc <= target; fetch_valid=0, squashing the wrong-path fetch; stay in RUN, whatever hit and stall are.
  - hit=0: pc holds; fetch_valid=0; go to MISS. The refill is committed from this edge onward.
  - hit=1, stall=1: pc holds; fetch_valid=0.
  - hit=1, stall=0: fetch_valid=1; pc <= pc + INSTR_BYTES, wrapping.
- MISS:
  - pc holds and fetch_valid=0 until hit=1. The refill cannot be aborted.
  - PCSrc=1: pend_target <= target; pend_valid <= 1. A later PCSrc overwrites the queued target.
  - hit=1 with pend_valid=1, or with PCSrc=1 in the same cycle (the same-cycle target wins): pc <= target; fetch_valid=0; pend_valid <= 0; go to RUN.
  - hit=1, no redirect, stall=0: fetch_valid=1; pc <= pc + INSTR_BYTES; go to RUN.
  - hit=1, no redirect, stall=1: fetch_valid=0; pc holds; go to RUN.
- redirect_pending = pend_valid.
- miss_cycles increments on every clock edge taken while state=MISS and saturates at all-ones.

## Timing
- Reset values, applied asynchronously while rst=1:
  - instruction_address = RESET_PC
  - address_out = RESET_PC + INSTR_BYTES
  - fetch_valid = 0, forced while rst=1
  - redirect_pending = 0
  - miss_cycles = 0
  - state = RUN
- Reset asserted mid-miss or with a redirect queued discards the queued redirect and the MISS state immediately.
- fetch_valid is combinational from state, hit, stall, PCSrc and pend_valid, with no latency. The pc update lands on the same edge.
- A redirect in RUN takes 1 cycle: the target appears on instruction_address the cycle after PCSrc.
- A redirect in MISS is applied on the edge at which hit=1 arrives. It appears on instruction_address the following cycle.
- A miss of N cycles of hit=0 adds N to miss_cycles. The first miss cycle is spent in RUN and is not counted.
- Wrap: pc = 2^ADDR_W − INSTR_BYTES followed by a hit advances to 0.

## Test plan
- Reset, then hit=1, stall=0 for 3 cycles, RESET_PC=0 -> instruction_address 0, 4, 8, 12; fetch_valid=1 on each cycle; address_out 4, 8, 12, 16.
- At pc=8: stall=1 for 2 cycles, then PCSrc=1 with address_branch=0x40 -> pc holds at 8 through the stall cycles; pc becomes 0x40 the next cycle; fetch_valid=0 in the redirect cycle.
- At pc=0x40: hit=0 for 4 cycles, PCSrc=1 with address_branch=0x100 in the 2nd cycle, then hit=1 -> redirect_pending=1 from the 3rd cycle; pc stays 0x40 until hit; then pc=0x100; fetch_valid=0 throughout; miss_cycles=3; redirect_pending clears.
- In MISS, two PCSrc pulses with targets 0x200 then 0x300, then hit=1 -> pc=0x300.
- In MISS with redirect_pending=1, assert rst asynchronously between edges -> all outputs take their reset values immediately; the queued target is never applied after release.
- ADDR_W=8, pc=0xFC, hit=1 -> address_out=0x00; next pc=0x00. address_branch=0x13 -> pc=0x10, low bits masked. Force 2^CNT_W+5 MISS cycles with CNT_W=4 -> miss_cycles saturates at 15.

Source files
------------

// File: rtl/fetch_pc_generator.sv
`default_nettype none
// ============================================================================
// fetch_pc_generator : IF-stage program counter with miss freeze and queued
//                      branch redirect, plus a saturating miss-cycle counter.
// Revision 1.0
// ============================================================================
module fetch_pc_generator #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit,
    input  logic              stall,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] address_branch,
    output logic [ADDR_W-1:0] instruction_address,
    output logic [ADDR_W-1:0] address_out,
    output logic              fetch_valid,
    output logic              redirect_pending,
    output logic [CNT_W-1:0]  miss_cycles
);

    localparam logic [ADDR_W-1:0] C_INC        = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pend_target_q, pend_target_d;
    logic               pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]   miss_cycles_q;
    logic               fetch_valid_d;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_inc;

    assign target = address_branch & C_ALIGN_MASK;
    assign pc_inc = pc_q + C_INC;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        fetch_valid_d = 1'b0;
        case (state_q)
            RUN: begin
                if (PCSrc) begin
                    pc_d = target;
                end else if (!hit) begin
                    state_d = MISS;
                end else if (!stall) begin
                    fetch_valid_d = 1'b1;
                    pc_d          = pc_inc;
                end
            end
            MISS: begin
                if (hit) begin
                    state_d      = RUN;
                    pend_valid_d = 1'b0;
                    // A redirect arriving on the refill-complete cycle supersedes the queued one.
                    if (PCSrc) begin
                        pc_d = target;
                    end else if (pend_valid_q) begin
                        pc_d = pend_target_q;
                    end else if (!stall) begin
                        fetch_valid_d = 1'b1;
                        pc_d          = pc_inc;
                    end
                end else if (PCSrc) begin
                    pend_target_d = target;
                    pend_valid_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cycles_q <= '0;
        end else if (state_q == MISS && miss_cycles_q != '1) begin
            miss_cycles_q <= miss_cycles_q + 1'b1;
        end
    end

    assign instruction_address = pc_q;
    assign address_out         = pc_inc;
    assign fetch_valid         = fetch_valid_d & ~rst;
    assign redirect_pending    = pend_valid_q;
    assign miss_cycles         = miss_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_generator.sv
`default_nettype none
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_fetch_pc_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 32-bit defaults
    logic        rst_a = 1'b1, hit_a = 1'b0, stall_a = 1'b0, pcsrc_a = 1'b0;
    logic [31:0] br_a = '0, ia_a, ao_a;
    logic        fv_a, rp_a;
    logic [15:0] mc_a;

    // DUT B: 8-bit address, 4-bit counter
    logic        rst_b = 1'b1, hit_b = 1'b0, stall_b = 1'b0, pcsrc_b = 1'b0;
    logic [7:0]  br_b = '0, ia_b, ao_b;
    logic        fv_b, rp_b;
    logic [3:0]  mc_b;

    fetch_pc_generator u_dut_a (
        .clk(clk), .rst(rst_a), .hit(hit_a), .stall(stall_a), .PCSrc(pcsrc_a),
        .address_branch(br_a), .instruction_address(ia_a), .address_out(ao_a),
        .fetch_valid(fv_a), .redirect_pending(rp_a), .miss_cycles(mc_a)
    );

    fetch_pc_generator #(.ADDR_W(8), .RESET_PC(8'h00), .INSTR_BYTES(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .hit(hit_b), .stall(stall_b), .PCSrc(pcsrc_b),
        .address_branch(br_b), .instruction_address(ia_b), .address_out(ao_b),
        .fetch_valid(fv_b), .redirect_pending(rp_b), .miss_cycles(mc_b)
    );

    typedef struct {
        int          id;
        bit          bsel;
        logic [31:0] ia;
        logic [31:0] ao;
        logic        fv;
        logic        rp;
        logic [15:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_id  = 0;
    bit   bsel     = 1'b0;

    task automatic chk(input int id, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL step %0d %s: got %h expected %h", id, f, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue the outputs expected for that cycle.
    task automatic step(input logic r, input logic h, input logic s, input logic p,
                        input logic [31:0] br, input logic [31:0] eia, input logic [31:0] eao,
                        input logic efv, input logic erp, input logic [15:0] emc);
        exp_t e;
        @(posedge clk);
        #2;
        if (!bsel) begin
            rst_a = r; hit_a = h; stall_a = s; pcsrc_a = p; br_a = br;
        end else begin
            rst_b = r; hit_b = h; stall_b = s; pcsrc_b = p; br_b = br[7:0];
        end
        e.id = step_id; e.bsel = bsel; e.ia = eia; e.ao = eao;
        e.fv = efv; e.rp = erp; e.mc = emc;
        exp_q.push_back(e);
        step_id++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.bsel) begin
                chk(e.id, "instruction_address", ia_a, e.ia);
                chk(e.id, "address_out", ao_a, e.ao);
                chk(e.id, "fetch_valid", {31'b0, fv_a}, {31'b0, e.fv});
                chk(e.id, "redirect_pending", {31'b0, rp_a}, {31'b0, e.rp});
                chk(e.id, "miss_cycles", {16'b0, mc_a}, {16'b0, e.mc});
            end else begin
                chk(e.id, "b.instruction_address", {24'b0, ia_b}, e.ia);
                chk(e.id, "b.address_out", {24'b0, ao_b}, e.ao);
                chk(e.id, "b.fetch_valid", {31'b0, fv_b}, {31'b0, e.fv});
                chk(e.id, "b.redirect_pending", {31'b0, rp_b}, {31'b0, e.rp});
                chk(e.id, "b.miss_cycles", {16'b0, mc_b}, {16'b0, e.mc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        //     rst hit stl pcs branch        ia            ao            fv rp mc
        // reset held with hit=1: fetch_valid forced low
        step(1, 1, 0, 0, 32'h0,   32'h0,   32'h4,   0, 0, 0);
        step(1, 1, 0, 0, 32'h0,   32'h0,   32'h4,   0, 0, 0);
        // sequential fetch
        step(0, 1, 0, 0, 32'h0,   32'h0,   32'h4,   1, 0, 0);
        step(0, 1, 0, 0, 32'h0,   32'h4,   32'h8,   1, 0, 0);
        // stall at pc=8, then redirect to 0x40
        step(0, 1, 1, 0, 32'h0,   32'h8,   32'hC,   0, 0, 0);
        step(0, 1, 1, 0, 32'h0,   32'h8,   32'hC,   0, 0, 0);
        step(0, 1, 0, 1, 32'h40,  32'h8,   32'hC,   0, 0, 0);
        // miss at 0x40, redirect 0x100 queued in the 2nd miss cycle
        step(0, 0, 0, 0, 32'h0,   32'h40,  32'h44,  0, 0, 0);
        step(0, 0, 0, 1, 32'h100, 32'h40,  32'h44,  0, 0, 0);
        step(0, 0, 0, 0, 32'h0,   32'h40,  32'h44,  0, 1, 1);
        step(0, 0, 0, 0, 32'h0,   32'h40,  32'h44,  0, 1, 2);
        step(0, 1, 0, 0, 32'h0,   32'h40,  32'h44,  0, 1, 3);
        step(0, 1, 0, 0, 32'h0,   32'h100, 32'h104, 1, 0, 4);
        // miss with two redirects: last one wins
        step(0, 0, 0, 0, 32'h0,   32'h104, 32'h108, 0, 0, 4);
        step(0, 0, 0, 1, 32'h200, 32'h104, 32'h108, 0, 0, 4);
        step(0, 0, 0, 1, 32'h300, 32'h104, 32'h108, 0, 1, 5);
        step(0, 1, 0, 0, 32'h0,   32'h104, 32'h108, 0, 1, 6);
        step(0, 1, 0, 0, 32'h0,   32'h300, 32'h304, 1, 0, 7);
        // miss with queued redirect, then asynchronous reset mid-cycle
        step(0, 0, 0, 0, 32'h0,   32'h304, 32'h308, 0, 0, 7);
        step(0, 0, 0, 1, 32'h500, 32'h304, 32'h308, 0, 0, 7);
        step(1, 0, 0, 0, 32'h0,   32'h0,   32'h4,   0, 0, 0);
        step(1, 1, 0, 0, 32'h0,   32'h0,   32'h4,   0, 0, 0);
        step(0, 1, 0, 0, 32'h0,   32'h0,   32'h4,   1, 0, 0);
        // queued 0x500 must not reappear; miss ending under stall holds pc
        step(0, 0, 0, 0, 32'h0,   32'h4,   32'h8,   0, 0, 0);
        step(0, 1, 1, 0, 32'h0,   32'h4,   32'h8,   0, 0, 0);
        step(0, 1, 0, 0, 32'h0,   32'h4,   32'h8,   1, 0, 1);
        // same-cycle redirect on refill completion, target low bits masked
        step(0, 0, 0, 0, 32'h0,   32'h8,   32'hC,   0, 0, 1);
        step(0, 1, 0, 1, 32'h81,  32'h8,   32'hC,   0, 0, 1);
        // redirect in RUN beats hit=0
        step(0, 0, 0, 1, 32'h20,  32'h80,  32'h84,  0, 0, 2);
        step(0, 1, 0, 0, 32'h0,   32'h20,  32'h24,  1, 0, 2);
        step(0, 1, 0, 0, 32'h0,   32'h24,  32'h28,  1, 0, 2);

        // 8-bit instance: masking, wrap, counter saturation
        bsel = 1'b1;
        step(1, 1, 0, 0, 32'h0,   32'h00,  32'h04,  0, 0, 0);
        step(0, 1, 0, 1, 32'h13,  32'h00,  32'h04,  0, 0, 0);
        step(0, 1, 0, 1, 32'hFC,  32'h10,  32'h14,  0, 0, 0);
        step(0, 1, 0, 0, 32'h0,   32'hFC,  32'h00,  1, 0, 0);
        step(0, 0, 0, 0, 32'h0,   32'h00,  32'h04,  0, 0, 0);
        for (int k = 0; k < 21; k++) begin
            step(0, 0, 0, 0, 32'h0, 32'h00, 32'h04, 0, 0, (k > 15) ? 16'd15 : 16'(k));
        end
        step(0, 1, 0, 0, 32'h0,   32'h00,  32'h04,  1, 0, 15);
        step(0, 1, 0, 0, 32'h0,   32'h04,  32'h08,  1, 0, 15);

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
